// File: rtl/mem_if_pkg.sv
// Shared definitions for the CPU data-memory interface.
// Used by both the MEM_stage initiator and the data-memory responder.
package mem_if_pkg;

    localparam int unsigned MEM_WORD_BYTES = 4;
    localparam int unsigned MEM_BE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    function automatic logic [MEM_BE_W*8-1:0] be_mask(
        input logic [MEM_BE_W-1:0] be
    );
        logic [MEM_BE_W*8-1:0] m;
        for (int i = 0; i < MEM_BE_W; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/be_merge.sv
// Byte-lane merge of store data into an existing RAM word.
// Lanes with be=1 take wdata, the rest keep the old word.
module be_merge
    import mem_if_pkg::*;
(
    input  logic [31:0]         old_word,
    input  logic [31:0]         wdata,
    input  logic [MEM_BE_W-1:0] be,
    output logic [31:0]         merged
);

    logic [31:0] mask;

    assign mask   = be_mask(be);
    assign merged = (old_word & ~mask) | (wdata & mask);

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency responder for the CPU data-memory port.
// One request in flight; backs a word-addressed on-chip RAM.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 512,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    input  logic [MEM_BE_W-1:0] req_be,
    output logic                resp_valid,
    output logic [31:0]         resp_rdata,
    output logic                resp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(LATENCY + 1);
    localparam int unsigned LSB = $clog2(MEM_WORD_BYTES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    mem_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;

    logic                we_q;
    logic                err_q;
    logic [AW-1:0]       idx_q;
    logic [31:0]         wdata_q;
    logic [MEM_BE_W-1:0] be_q;
    logic [31:0]         rd_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [32:0]   off;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] rd_idx;
    logic          req_err;
    logic          accept;
    logic          wr_en;
    logic [31:0]   merged;

    // 33-bit offset so a request below BASE_ADDR shows up as a borrow
    assign off     = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    assign req_idx = off[AW+LSB-1:LSB];
    assign req_err = (off[LSB-1:0] != '0)
                   || off[32]
                   || (off[31:AW+LSB] != '0);

    assign req_ready = (state == IDLE) && !RST;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nx   = CNT_LOAD;
                    state_nx = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nx = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    state_nx = RESP;
                end
            end
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            err_q   <= req_err;
            idx_q   <= req_idx;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    // Read port follows the live request in IDLE so LATENCY=1 still works
    assign rd_idx = (state == IDLE) ? req_idx : idx_q;

    always_ff @(posedge CLK) begin
        rd_q <= mem[rd_idx];
    end

    be_merge u_be_merge (
        .old_word (mem[idx_q]),
        .wdata    (wdata_q),
        .be       (be_q),
        .merged   (merged)
    );

    assign wr_en = (state == RESP) && we_q && !err_q && !RST;

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[idx_q] <= merged;
        end
    end

    assign resp_valid = (state == RESP) && !RST;
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !we_q && !err_q) ? rd_q : '0;

endmodule
